// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - per-frame bird motion and game-state sequencer
// Optional hover bob in IDLE enabled by defining BIRD_IDLE_BOB_EN.
module bird_motion_ctrl #(
  parameter logic signed [15:0] Y_INIT     = 16'sd200,
  parameter logic signed [15:0] Y_MIN      = 16'sd0,
  parameter logic signed [15:0] Y_GROUND   = 16'sd400,
  parameter logic signed [15:0] GRAVITY    = 16'sd1,
  parameter logic signed [15:0] VEL_MAX    = 16'sd10,
  parameter logic signed [15:0] FLAP_VEL   = -16'sd8,
  parameter logic signed [7:0]  ANGLE_UP   = -8'sd20,
  parameter logic signed [7:0]  ANGLE_MAX  = 8'sd63,
  parameter logic signed [7:0]  ANGLE_STEP = 8'sd3,
  parameter int                 ANIM_DIV   = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               flap,
  input  logic               hit,
  output logic signed [15:0] pos_y,
  output logic signed [7:0]  angle,
  output logic [1:0]         bird_status,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_DEAD = 2'd3} state_t;
  localparam logic [2:0] ANIM_LAST = 3'(ANIM_DIV - 1);

  state_t             state_q;
  logic signed [15:0] vel, vel_g, mv_vel, ny, nxt_pos, nxt_vel, idle_y;
  logic signed [7:0]  ang_g, ang_sum, mv_ang;
  logic [2:0]         cnt, cnt_n;
  logic [1:0]         phase, phase_n, status_n;
  logic               start_pend, flap_pend, hit_pend;
  logic               start_now, flap_now, hit_now, do_flap, grounded;

  // A request arriving on the tick cycle itself is honoured by that tick.
  assign start_now = start_pend | start;
  assign flap_now  = flap_pend | flap;
  assign hit_now   = hit_pend | hit;
  assign state     = state_q;

  always_comb begin
    vel_g = vel + GRAVITY;
    if (vel_g > VEL_MAX) vel_g = VEL_MAX;
    ang_g = angle;
    if (!vel_g[15]) begin
      ang_sum = angle + ANGLE_STEP;
      ang_g   = (ang_sum > ANGLE_MAX) ? ANGLE_MAX : ang_sum;
    end else begin
      ang_sum = angle;
    end
    do_flap = flap_now && (state_q == S_IDLE || state_q == S_PLAY);
    mv_vel  = do_flap ? FLAP_VEL : vel_g;
    mv_ang  = do_flap ? ANGLE_UP : ang_g;
    ny      = pos_y + mv_vel;
    nxt_pos  = ny;
    nxt_vel  = mv_vel;
    grounded = 1'b0;
    if (ny < Y_MIN) begin
      nxt_pos = Y_MIN;
      nxt_vel = 16'sd0;
    end else if (ny >= Y_GROUND) begin
      nxt_pos  = Y_GROUND;
      nxt_vel  = 16'sd0;
      grounded = 1'b1;
    end
    if (cnt == ANIM_LAST) begin
      cnt_n   = 3'd0;
      phase_n = phase + 2'd1;
    end else begin
      cnt_n   = cnt + 3'd1;
      phase_n = phase;
    end
    case (phase_n)
      2'd1, 2'd3: status_n = 2'd1;
      2'd2:       status_n = 2'd2;
      default:    status_n = 2'd0;
    endcase
`ifdef BIRD_IDLE_BOB_EN
    case (phase_n)
      2'd1:    idle_y = Y_INIT - 16'sd2;
      2'd3:    idle_y = Y_INIT + 16'sd2;
      default: idle_y = Y_INIT;
    endcase
`else
    idle_y = Y_INIT;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_y       <= Y_INIT;
      vel         <= 16'sd0;
      angle       <= 8'sd0;
      bird_status <= 2'd0;
      state_q     <= S_IDLE;
      cnt         <= 3'd0;
      phase       <= 2'd0;
      start_pend  <= 1'b0;
      flap_pend   <= 1'b0;
      hit_pend    <= 1'b0;
    end else begin
      if (frame_tick) begin
        start_pend <= 1'b0;
        flap_pend  <= 1'b0;
        hit_pend   <= 1'b0;
      end else begin
        start_pend <= start_now;
        flap_pend  <= flap_now;
        hit_pend   <= hit_now;
      end
      if (frame_tick) begin
        case (state_q)
          S_IDLE: begin
            cnt         <= cnt_n;
            phase       <= phase_n;
            bird_status <= status_n;
            if (do_flap) begin
              state_q <= S_PLAY;
              pos_y   <= nxt_pos;
              vel     <= nxt_vel;
              angle   <= mv_ang;
            end else begin
              pos_y <= idle_y;
              vel   <= 16'sd0;
              angle <= 8'sd0;
            end
          end
          S_PLAY: begin
            cnt         <= cnt_n;
            phase       <= phase_n;
            bird_status <= status_n;
            if (hit_now) begin
              state_q <= S_DYING;
            end else begin
              pos_y <= nxt_pos;
              vel   <= nxt_vel;
              angle <= mv_ang;
              if (grounded) state_q <= S_DEAD;
            end
          end
          S_DYING: begin
            pos_y <= nxt_pos;
            vel   <= nxt_vel;
            angle <= mv_ang;
            if (grounded) state_q <= S_DEAD;
          end
          default: begin
            if (start_now) begin
              state_q     <= S_IDLE;
              pos_y       <= Y_INIT;
              vel         <= 16'sd0;
              angle       <= 8'sd0;
              cnt         <= 3'd0;
              phase       <= 2'd0;
              bird_status <= 2'd0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb/tb_bird_motion_ctrl.sv - directed self-checking bench for bird_motion_ctrl
module tb_bird_motion_ctrl;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               frame_tick = 1'b0, start = 1'b0, flap = 1'b0, hit = 1'b0;
  logic signed [15:0] pos_y;
  logic signed [7:0]  angle;
  logic [1:0]         bird_status, state;

  int checks = 0, errors = 0;
  int n = 0;
  int pos_m, vel_m, ang_m;

  bird_motion_ctrl dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .start(start), .flap(flap), .hit(hit),
    .pos_y(pos_y), .angle(angle), .bird_status(bird_status), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int p, input int a, input int s, input int st);
    chk({tag, "_pos_y"}, 32'(pos_y), p);
    chk({tag, "_angle"}, 32'(angle), a);
    chk({tag, "_status"}, {30'd0, bird_status}, s);
    chk({tag, "_state"}, {30'd0, state}, st);
  endtask

  function automatic int stat(input int k);
    case ((k / 6) % 4)
      1, 3:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int idle_pos(input int k);
`ifdef BIRD_IDLE_BOB_EN
    case ((k / 6) % 4)
      1:       return 198;
      3:       return 202;
      default: return 200;
    endcase
`else
    return 200 + 0 * k;
`endif
  endfunction

  task automatic drive(input bit t, input bit f, input bit h, input bit s);
    @(negedge clk);
    frame_tick = t; flap = f; hit = h; start = s;
    @(negedge clk);
    frame_tick = 0; flap = 0; hit = 0; start = 0;
  endtask

  task automatic fall(input bit anim_on, input int st_live);
    bit dead = 0;
    for (int k = 0; k < 60 && !dead; k++) begin
      vel_m = (vel_m + 1 > 10) ? 10 : vel_m + 1;
      if (vel_m >= 0) ang_m = (ang_m + 3 > 63) ? 63 : ang_m + 3;
      pos_m += vel_m;
      if (pos_m >= 400) begin pos_m = 400; vel_m = 0; dead = 1; end
      drive(1, 0, 0, 0);
      if (anim_on) n++;
      check_all("fall", pos_m, ang_m, stat(n), dead ? 3 : st_live);
    end
    chk("fall_reached_ground", 32'(pos_y), 400);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset", 200, 0, 0, 0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0);
      n++;
      check_all("idle", idle_pos(n), 0, stat(n), 0);
    end

    drive(1, 0, 0, 0) ;
    n++;
    check_all("idle11", idle_pos(n), 0, stat(n), 0);

    pos_m = idle_pos(n) - 8; vel_m = -8; ang_m = -20;
    drive(1, 1, 0, 0);
    n++;
    check_all("flap_enter", pos_m, -20, stat(n), 1);

    fall(1, 1);
    chk("angle_cap", 32'(angle), 63);

    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0);
      check_all("dead_frozen", 400, 63, stat(n), 3);
    end

    drive(0, 0, 0, 1);
    chk("start_no_tick_state", {30'd0, state}, 3);
    drive(1, 0, 0, 0);
    n = 0;
    check_all("restart", 200, 0, 0, 0);

    drive(1, 1, 0, 0);
    n++;
    pos_m = 192; vel_m = -8; ang_m = -20;
    check_all("flap2", 192, -20, stat(n), 1);

    drive(1, 1, 1, 0);
    n++;
    check_all("hit_flap", 192, -20, stat(n), 2);

    fall(0, 2);

    drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    n = 0;
    check_all("restart2", 200, 0, 0, 0);

    pos_m = 200;
    for (int i = 0; i < 27; i++) begin
      drive(1, 1, 0, 0);
      n++;
      pos_m = (pos_m - 8 < 0) ? 0 : pos_m - 8;
      check_all("ceiling", pos_m, -20, stat(n), 1);
    end

    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_all("async_reset", 200, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 0, 0);
    check_all("after_reset", 200, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
